// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid buffer with registered s_ready
// Optional stall counter enabled by macro PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNTW-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             ready_q;
  logic             load_main;
  logic             load_skid;
  logic             main_from_skid;
  logic             up_xfer;
  logic             dn_xfer;

  assign m_valid = (state != EMPTY);
  assign s_ready = ready_q;
  assign m_data  = main_q;
  assign up_xfer = s_valid & ready_q;
  assign dn_xfer = m_valid & m_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (up_xfer) begin
          load_main = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (up_xfer && dn_xfer) begin
          load_main = 1'b1;
        end else if (up_xfer) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (dn_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (m_ready) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush discards everything buffered; the registers simply keep stale data.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != FULL);
      if (load_main) main_q <= main_from_skid ? skid_q : s_data;
      if (load_skid) skid_q <= s_data;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (m_valid && !m_ready && (cnt_q != {CNTW{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - queue-model checker for pipe_skid_stage
// Honours PIPE_SKID_STALL_CNT_EN for the expected stall count.
module tb_pipe_skid_stage;
  localparam int WIDTH = 32;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             reset, flush, s_valid, m_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_ready, m_valid;
  logic [WIDTH-1:0] m_data;
  logic [CNTW-1:0]  stall_cnt;

  pipe_skid_stage #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mq[$];
  logic             m_rdy   = 1'b0;
  int               m_stall = 0;
  bit               started = 1'b0;
  logic [WIDTH-1:0] last_out = '0;

  // Occupancy model: a FIFO of at most two beats, ready whenever not full.
  always @(posedge clk) begin
    bit up, dn;
    started <= 1'b1;
    if (reset) begin
      mq.delete();
      m_rdy   = 1'b0;
      m_stall = 0;
    end else begin
      up = s_valid && m_rdy;
      dn = (mq.size() > 0) && m_ready;
`ifdef PIPE_SKID_STALL_CNT_EN
      if ((mq.size() > 0) && !m_ready && m_stall < (1 << CNTW) - 1) m_stall++;
`endif
      if (dn) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (up) mq.push_back(s_data);
      m_rdy = (mq.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      total++;
      if (m_valid !== (mq.size() > 0)) begin
        bad++;
        $display("FAIL model_m_valid: got %0b want %0b at %0t", m_valid, mq.size() > 0, $time);
      end
      total++;
      if (s_ready !== m_rdy) begin
        bad++;
        $display("FAIL model_s_ready: got %0b want %0b at %0t", s_ready, m_rdy, $time);
      end
      total++;
      if (stall_cnt !== CNTW'(m_stall)) begin
        bad++;
        $display("FAIL model_stall_cnt: got %0d want %0d at %0t", stall_cnt, m_stall, $time);
      end
      if (mq.size() > 0) begin
        total++;
        if (m_data !== mq[0]) begin
          bad++;
          $display("FAIL model_m_data: got %h want %h at %0t", m_data, mq[0], $time);
        end
      end
      if (m_valid && m_ready) last_out = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  int exp_stall_skid, exp_stall_sat;

  initial begin
`ifdef PIPE_SKID_STALL_CNT_EN
    exp_stall_skid = 2;
    exp_stall_sat  = 15;
`else
    exp_stall_skid = 0;
    exp_stall_sat  = 0;
`endif
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    step();
    chk("rst_s_ready", {31'b0, s_ready}, 0);
    chk("rst_m_valid", {31'b0, m_valid}, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_stall", {28'b0, stall_cnt}, 0);
    step();
    reset = 1'b0;
    step();
    chk("idle_s_ready", {31'b0, s_ready}, 1);

    // Streaming
    m_ready = 1'b1; s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_data = i;
      step();
      chk("stream_data", m_data, i);
      chk("stream_s_ready", {31'b0, s_ready}, 1);
    end
    s_valid = 1'b0;
    step();
    chk("stream_drain", {31'b0, m_valid}, 0);

    // Skid fill
    s_valid = 1'b1; s_data = 32'hA;
    step();
    m_ready = 1'b0; s_data = 32'hB;
    step();
    chk("skid_s_ready", {31'b0, s_ready}, 0);
    chk("skid_main", m_data, 32'hA);
    s_valid = 1'b0;
    step();
    chk("skid_hold", m_data, 32'hA);
    chk("skid_stall", {28'b0, stall_cnt}, exp_stall_skid);
    m_ready = 1'b1;
    step();
    chk("skid_second", m_data, 32'hB);
    chk("skid_ready_back", {31'b0, s_ready}, 1);
    chk("skid_first_out", last_out, 32'hA);
    step();
    chk("skid_done", {31'b0, m_valid}, 0);
    chk("skid_second_out", last_out, 32'hB);

    // Flush in FULL
    m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h11;
    step();
    s_data = 32'h12;
    step();
    s_valid = 1'b0; flush = 1'b1;
    step();
    chk("flushfull_m_valid", {31'b0, m_valid}, 0);
    chk("flushfull_s_ready", {31'b0, s_ready}, 1);
    flush = 1'b0; m_ready = 1'b1;
    step();
    chk("flushfull_nothing", {31'b0, m_valid}, 0);

    // Flush with simultaneous transfers
    s_valid = 1'b1; s_data = 32'h5;
    step();
    s_data = 32'h6; flush = 1'b1;
    step();
    chk("flushxfer_consumed", last_out, 32'h5);
    chk("flushxfer_empty", {31'b0, m_valid}, 0);
    flush = 1'b0; s_valid = 1'b0;
    step();
    chk("flushxfer_dropped", {31'b0, m_valid}, 0);

    // Mid-traffic reset
    m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h21;
    step();
    s_data = 32'h22;
    step();
    reset = 1'b1; s_valid = 1'b0;
    step();
    chk("midrst_m_valid", {31'b0, m_valid}, 0);
    chk("midrst_m_data", m_data, 0);
    chk("midrst_stall", {28'b0, stall_cnt}, 0);
    reset = 1'b0;
    step();
    s_valid = 1'b1; s_data = 32'h33; m_ready = 1'b1;
    step();
    chk("midrst_resume", m_data, 32'h33);
    s_valid = 1'b0;
    step();

    // Stall counter saturation
    s_valid = 1'b1; s_data = 32'h44; m_ready = 1'b0;
    step();
    s_valid = 1'b0;
    repeat (20) step();
    chk("sat_stall", {28'b0, stall_cnt}, exp_stall_sat);
    chk("sat_hold_data", m_data, 32'h44);
    m_ready = 1'b1;
    step();
    step();
    chk("sat_after_drain", {28'b0, stall_cnt}, exp_stall_sat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Two-entry elastic pipeline register (skid buffer) that joins an upstream valid/ready producer to a downstream valid/ready consumer. It generates the load-enable and clear for its own data registers, so pipeline stages are built from handshakes rather than from hand-wired stall and flush enables. It sits between core pipeline stages and on bus response paths. It registers the backpressure path so that `s_ready` never depends combinationally on `m_ready`.

## Interface
- `WIDTH`, default 32: payload width in bits.
- `CNTW`, default 16: width of the stall counter.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous reset, active-high.
- `flush`  in  1: synchronous clear of all buffered entries.
- `s_valid`  in  1: upstream payload valid.
- `s_ready`  out  1: stage can accept; registered, a function of state only.
- `s_data`  in  WIDTH: upstream payload.
- `m_valid`  out  1: downstream payload valid.
- `m_ready`  in  1: downstream accepts.
- `m_data`  out  WIDTH: downstream payload, driven directly from the main register.
- `stall_cnt`  out  CNTW: count of downstream stall cycles; tied to 0 when the feature is compiled out.

## Operation
- Storage is two registers. `main` drives `m_data`. `skid` holds the beat that arrives while `main` is blocked.
- A register is written only on a load. It holds its value otherwise.
- State machine:
  - EMPTY: `m_valid`=0, `s_ready`=1.
  - BUSY: `m_valid`=1, `s_ready`=1.
  - FULL: `m_valid`=1, `s_ready`=0.
- Transfer definitions:
  - Upstream transfer: `s_valid & s_ready`.
  - Downstream transfer: `m_valid & m_ready`.
- Transitions when `flush`=0:
  - EMPTY + upstream transfer: `main`<=`s_data`, go to BUSY.
  - BUSY + upstream transfer + downstream transfer: `main`<=`s_data`, stay in BUSY.
  - BUSY + upstream transfer, no downstream transfer: `skid`<=`s_data`, go to FULL.
  - BUSY + downstream transfer only: go to EMPTY.
  - FULL + `m_ready`: `main`<=`skid`, go to BUSY.
  - FULL with `m_ready`=0: hold. No upstream transfer is possible in FULL.
  - Any other case: hold.
- Flush:
  - `flush`=1 forces the next state to EMPTY, overriding every transition.
  - A beat offered upstream in the flush cycle is dropped, even though `s_ready` may be 1 in that cycle.
  - A downstream transfer in the flush cycle completes normally; the consumer keeps that beat.
  - Data registers are not cleared by flush.
- Reset: state goes to EMPTY; `main`, `skid` and `stall_cnt` go to 0. Reset overrides flush.
- Reset values of outputs: `s_ready`=0 during the reset cycle, then 1 in EMPTY; `m_valid`=0; `m_data`=0; `stall_cnt`=0.
- Ordering: beats leave in arrival order. No beat is duplicated or lost, except beats discarded by flush.
- `m_data` is stable while `m_valid & !m_ready`.

## Timing
- Latency: 1 cycle. A beat accepted at edge N appears on `m_valid`/`m_data` after edge N.
- Throughput: 1 beat per cycle while `m_ready` is held at 1.
- `s_ready` is a registered output. Deasserting `m_ready` still lets one more beat be accepted (into `skid`), and `s_ready` drops from the following cycle.
- After `m_ready` re-asserts in FULL, `s_ready` returns to 1 one cycle later.
- No combinational path from `m_ready` to `s_ready`, or from `s_valid` to `m_valid`.

## Configuration
- Macro `PIPE_SKID_STALL_CNT_EN`.
- Defined:
  - `stall_cnt` increments on every cycle where `m_valid & !m_ready`.
  - It saturates at 2^CNTW−1.
  - It is cleared only by reset; flush does not clear it.
- Undefined: the counter logic is absent and `stall_cnt` is constant 0.

## Test plan
- Streaming: hold `m_ready`=1 and send 0x1,0x2,0x3 back-to-back → `m_data` shows 0x1,0x2,0x3 on consecutive cycles, one cycle delayed; `s_ready` stays 1.
- Skid fill: in BUSY with 0xA in `main`, drop `m_ready` and offer 0xB → 0xB accepted and `s_ready`=0 next cycle. Raise `m_ready` → 0xA, then 0xB delivered; `s_ready`=1 one cycle after `m_ready` rises.
- Flush in FULL: hold two beats, pulse `flush` with `m_ready`=0 → `m_valid`=0 and `s_ready`=1 next cycle; nothing further delivered.
- Flush with simultaneous transfers: BUSY holding 0x5, `m_ready`=1, offer 0x6 with `flush`=1 → 0x5 is consumed, 0x6 is dropped, state EMPTY.
- Mid-traffic reset: assert `reset` in FULL → next cycle `m_valid`=0, `m_data`=0, `stall_cnt`=0; normal operation on the first beat afterwards.
- With `PIPE_SKID_STALL_CNT_EN` and `CNTW`=4: hold `m_valid`=1, `m_ready`=0 for 20 cycles → `stall_cnt` saturates at 15. With the macro undefined, it reads 0.
